// File: rtl/control_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : control_sequencer_pkg
//  Purpose  : Shared types and constants for the accumulator-datapath
//             instruction sequencer: opcodes, FSM states, ACC-bus source
//             and ALU op encodings, and instruction field positions.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package control_sequencer_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_GET   = 4'd1,
    OP_PUT   = 4'd2,
    OP_LOADI = 4'd3,
    OP_LOAD  = 4'd4,
    OP_STORE = 4'd5,
    OP_ADD   = 4'd8,
    OP_SUB   = 4'd9,
    OP_AND   = 4'd10,
    OP_OR    = 4'd11,
    OP_HALT  = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_HALTED = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ACC_SRC_NONE = 2'd0,
    ACC_SRC_ALU  = 2'd1,
    ACC_SRC_IMM  = 2'd2,
    ACC_SRC_DMEM = 2'd3
  } acc_src_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  // Instruction field positions (16-bit instruction word)
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int ALU_MSB = 13;
  localparam int ALU_LSB = 12;
  localparam int IMM_MSB = 11;
  localparam int IMM_LSB = 4;
  localparam int REG_MSB = 3;
  localparam int REG_LSB = 0;

endpackage
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : control_sequencer
//  Purpose  : Multi-cycle fetch/decode/execute sequencer that drives the
//             register file strobes, ALU op, ACC-bus source select and the
//             data-memory handshake.
//  Ports    : clk, reset_n (sync, active-low), run
//             imem_req/imem_ack/imem_rdata   instruction fetch port
//             dmem_req/dmem_we/dmem_ack      data memory handshake
//             reg_addr, acc_write_enable, read_get_to_acc, write_put_acc,
//             read_data_output_enable, status_write_enable  register file
//             acc_src, imm, alu_op           datapath selects
//             pc_advance, retired_count, halted, illegal_op  status
//  Revision : 1.0  initial release
// ============================================================================
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int INSTR_W        = 16,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int COUNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      run,
  output logic                      imem_req,
  input  logic                      imem_ack,
  input  logic [INSTR_W-1:0]        imem_rdata,
  output logic                      dmem_req,
  output logic                      dmem_we,
  input  logic                      dmem_ack,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr,
  output logic                      acc_write_enable,
  output logic                      read_get_to_acc,
  output logic                      write_put_acc,
  output logic                      read_data_output_enable,
  output logic                      status_write_enable,
  output logic [1:0]                acc_src,
  output logic [DATA_W-1:0]         imm,
  output logic [1:0]                alu_op,
  output logic                      pc_advance,
  output logic [COUNT_W-1:0]        retired_count,
  output logic                      halted,
  output logic                      illegal_op
);

  state_e               r_state;
  logic [INSTR_W-1:0]   r_ir;
  logic [COUNT_W-1:0]   r_retired_count;

  opcode_e              w_op;
  logic                 w_retire;

  assign retired_count = r_retired_count;

  // Decoder: everything is a function of r_state/r_ir, except the MEM
  // ack cycle, where completion (and the LOAD ACC write) follows dmem_ack.
  always_comb begin
    w_op                    = opcode_e'(r_ir[OPC_MSB:OPC_LSB]);
    w_retire                = 1'b0;
    imem_req                = 1'b0;
    dmem_req                = 1'b0;
    dmem_we                 = 1'b0;
    reg_addr                = '0;
    imm                     = '0;
    alu_op                  = '0;
    acc_write_enable        = 1'b0;
    read_get_to_acc         = 1'b0;
    write_put_acc           = 1'b0;
    read_data_output_enable = 1'b0;
    status_write_enable     = 1'b0;
    acc_src                 = ACC_SRC_NONE;
    illegal_op              = 1'b0;
    halted                  = 1'b0;

    // Instruction fields are presented from DECODE until the instruction leaves.
    if (r_state == ST_DECODE || r_state == ST_EXEC || r_state == ST_MEM) begin
      reg_addr = REG_ADDR_WIDTH'(r_ir[REG_MSB:REG_LSB]);
      imm      = DATA_W'(r_ir[IMM_MSB:IMM_LSB]);
      alu_op   = r_ir[ALU_MSB:ALU_LSB];
    end

    case (r_state)
      ST_FETCH: imem_req = 1'b1;
      ST_EXEC: begin
        case (w_op)
          OP_NOP: w_retire = 1'b1;
          OP_GET: begin
            read_get_to_acc  = 1'b1;
            acc_write_enable = 1'b1;
            w_retire         = 1'b1;
          end
          OP_PUT: begin
            write_put_acc = 1'b1;
            w_retire      = 1'b1;
          end
          OP_LOADI: begin
            acc_src          = ACC_SRC_IMM;
            acc_write_enable = 1'b1;
            w_retire         = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            read_data_output_enable = 1'b1;
            acc_src                 = ACC_SRC_ALU;
            acc_write_enable        = 1'b1;
            status_write_enable     = 1'b1;
            w_retire                = 1'b1;
          end
          OP_LOAD, OP_STORE, OP_HALT: ;
          default: begin
            // Undefined opcode: flag it, then retire as a NOP.
            illegal_op = 1'b1;
            w_retire   = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (w_op == OP_STORE);
        if (dmem_ack) begin
          w_retire = 1'b1;
          if (w_op == OP_LOAD) begin
            acc_src          = ACC_SRC_DMEM;
            acc_write_enable = 1'b1;
          end
        end
      end
      ST_HALTED: halted = 1'b1;
      default: ;
    endcase

    pc_advance = w_retire;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_ir            <= '0;
      r_retired_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE:   if (run) r_state <= ST_FETCH;
        ST_FETCH: begin
          if (imem_ack) begin
            r_ir    <= imem_rdata;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: r_state <= ST_EXEC;
        ST_EXEC: begin
          if (w_op == OP_LOAD || w_op == OP_STORE) r_state <= ST_MEM;
          else if (w_op == OP_HALT)                r_state <= ST_HALTED;
        end
        ST_HALTED: r_state <= ST_HALTED;
        default:   ;
      endcase
      // Retirement decides the follow-on state for both EXEC and MEM.
      if (w_retire) begin
        r_state         <= run ? ST_FETCH : ST_IDLE;
        r_retired_count <= r_retired_count + COUNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_sequencer
//  Purpose  : Directed self-checking bench for control_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic [3:0]  reg_addr;
  logic        acc_write_enable;
  logic        read_get_to_acc;
  logic        write_put_acc;
  logic        read_data_output_enable;
  logic        status_write_enable;
  logic [1:0]  acc_src;
  logic [7:0]  imm;
  logic [1:0]  alu_op;
  logic        pc_advance;
  logic [15:0] retired_count;
  logic        halted;
  logic        illegal_op;

  int vectors    = 0;
  int miscompares = 0;

  control_sequencer dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .run                     (run),
    .imem_req                (imem_req),
    .imem_ack                (imem_ack),
    .imem_rdata              (imem_rdata),
    .dmem_req                (dmem_req),
    .dmem_we                 (dmem_we),
    .dmem_ack                (dmem_ack),
    .reg_addr                (reg_addr),
    .acc_write_enable        (acc_write_enable),
    .read_get_to_acc         (read_get_to_acc),
    .write_put_acc           (write_put_acc),
    .read_data_output_enable (read_data_output_enable),
    .status_write_enable     (status_write_enable),
    .acc_src                 (acc_src),
    .imm                     (imm),
    .alu_op                  (alu_op),
    .pc_advance              (pc_advance),
    .retired_count           (retired_count),
    .halted                  (halted),
    .illegal_op              (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle; inputs are changed and outputs sampled 1ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Structural invariants, checked on every falling edge out of reset.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      chk("inv_get_src",  {31'd0, read_get_to_acc && (acc_src != 2'd0)}, 32'd0);
      chk("inv_put_accwe", {31'd0, write_put_acc && acc_write_enable}, 32'd0);
      chk("inv_req_both", {31'd0, imem_req && dmem_req}, 32'd0);
    end
  end

  initial begin
    reset_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0000; dmem_ack = 1'b0;
    cyc(); cyc();
    reset_n = 1'b1; #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_halted", halted, 0);
    chk("rst_count", retired_count, 0);
    chk("rst_acc_src", acc_src, 0);
    chk("rst_pc_adv", pc_advance, 0);

    // LOADI 0xA5, zero wait; ack raised early is ignored while idle.
    run = 1'b1; imem_rdata = 16'h3A50; imem_ack = 1'b1;
    cyc(); chk("ldi_fetch_req", imem_req, 1);
    cyc(); imem_ack = 1'b0; #1;
    chk("ldi_dec_req", imem_req, 0);
    chk("ldi_dec_imm", imm, 8'hA5);
    chk("ldi_dec_accwe", acc_write_enable, 0);
    cyc();
    chk("ldi_exec_src", acc_src, 2);
    chk("ldi_exec_imm", imm, 8'hA5);
    chk("ldi_exec_accwe", acc_write_enable, 1);
    chk("ldi_exec_pcadv", pc_advance, 1);
    chk("ldi_exec_cnt", retired_count, 0);
    cyc();
    chk("ldi_next_req", imem_req, 1);
    chk("ldi_next_cnt", retired_count, 1);
    chk("ldi_next_pcadv", pc_advance, 0);

    // PUT R3
    imem_rdata = 16'h2003; imem_ack = 1'b1;
    cyc(); imem_ack = 1'b0; #1;
    cyc();
    chk("put_strobe", write_put_acc, 1);
    chk("put_reg", reg_addr, 3);
    chk("put_accwe", acc_write_enable, 0);
    chk("put_pcadv", pc_advance, 1);
    cyc();
    // GET R3
    imem_rdata = 16'h1003; imem_ack = 1'b1;
    cyc(); imem_ack = 1'b0; #1;
    cyc();
    chk("get_strobe", read_get_to_acc, 1);
    chk("get_src", acc_src, 0);
    chk("get_accwe", acc_write_enable, 1);
    chk("get_put", write_put_acc, 0);
    chk("get_reg", reg_addr, 3);
    chk("get_cnt", retired_count, 2);
    cyc();

    // SUB R5
    imem_rdata = 16'h9005; imem_ack = 1'b1;
    cyc(); imem_ack = 1'b0; #1;
    chk("sub_dec_rdoe", read_data_output_enable, 0);
    cyc();
    chk("sub_rdoe", read_data_output_enable, 1);
    chk("sub_accwe", acc_write_enable, 1);
    chk("sub_stwe", status_write_enable, 1);
    chk("sub_aluop", alu_op, 1);
    chk("sub_src", acc_src, 1);
    chk("sub_reg", reg_addr, 5);
    cyc();
    chk("sub_after_stwe", status_write_enable, 0);
    chk("sub_after_cnt", retired_count, 4);

    // LOAD with three wait cycles
    imem_rdata = 16'h4000; imem_ack = 1'b1;
    cyc(); imem_ack = 1'b0; #1;
    cyc();
    chk("ld_exec_dreq", dmem_req, 0);
    chk("ld_exec_pcadv", pc_advance, 0);
    chk("ld_exec_accwe", acc_write_enable, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("ld_wait_dreq", dmem_req, 1);
      chk("ld_wait_we", dmem_we, 0);
      chk("ld_wait_accwe", acc_write_enable, 0);
      chk("ld_wait_src", acc_src, 0);
      chk("ld_wait_pcadv", pc_advance, 0);
    end
    cyc(); dmem_ack = 1'b1; #1;
    chk("ld_ack_dreq", dmem_req, 1);
    chk("ld_ack_accwe", acc_write_enable, 1);
    chk("ld_ack_src", acc_src, 3);
    chk("ld_ack_pcadv", pc_advance, 1);
    cyc(); dmem_ack = 1'b0; #1;
    chk("ld_next_ireq", imem_req, 1);
    chk("ld_next_dreq", dmem_req, 0);
    chk("ld_next_cnt", retired_count, 5);

    // STORE with run dropped mid-instruction; one wait cycle
    imem_rdata = 16'h5000; imem_ack = 1'b1;
    cyc(); imem_ack = 1'b0; run = 1'b0; #1;
    cyc();
    cyc();
    chk("st_dreq", dmem_req, 1);
    chk("st_we", dmem_we, 1);
    cyc(); dmem_ack = 1'b1; #1;
    chk("st_ack_pcadv", pc_advance, 1);
    chk("st_ack_accwe", acc_write_enable, 0);
    cyc(); dmem_ack = 1'b0; #1;
    chk("st_idle_ireq", imem_req, 0);
    chk("st_idle_dreq", dmem_req, 0);
    chk("st_idle_cnt", retired_count, 6);
    cyc();
    chk("st_idle2_ireq", imem_req, 0);

    // Illegal opcode 7
    run = 1'b1;
    cyc(); imem_rdata = 16'h7000; imem_ack = 1'b1; #1;
    chk("ill_fetch_req", imem_req, 1);
    cyc(); imem_ack = 1'b0; #1;
    cyc();
    chk("ill_pulse", illegal_op, 1);
    chk("ill_pcadv", pc_advance, 1);
    chk("ill_accwe", acc_write_enable, 0);
    cyc();
    chk("ill_after", illegal_op, 0);
    chk("ill_cnt", retired_count, 7);

    // Reset during MEM, then a late ack
    imem_rdata = 16'h4000; imem_ack = 1'b1;
    cyc(); imem_ack = 1'b0; #1;
    cyc();
    cyc();
    chk("rmem_dreq", dmem_req, 1);
    reset_n = 1'b0; run = 1'b0;
    cyc(); reset_n = 1'b1; dmem_ack = 1'b1; #1;
    chk("rmem_dreq_drop", dmem_req, 0);
    chk("rmem_cnt", retired_count, 0);
    chk("rmem_accwe", acc_write_enable, 0);
    chk("rmem_pcadv", pc_advance, 0);
    cyc(); dmem_ack = 1'b0; #1;
    chk("rmem_idle_ireq", imem_req, 0);
    chk("rmem_idle_dreq", dmem_req, 0);

    // HALT
    run = 1'b1;
    cyc(); imem_rdata = 16'hF000; imem_ack = 1'b1; #1;
    cyc(); imem_ack = 1'b0; #1;
    cyc();
    chk("halt_exec_pcadv", pc_advance, 0);
    chk("halt_exec_halted", halted, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("halt_halted", halted, 1);
      chk("halt_ireq", imem_req, 0);
      chk("halt_pcadv", pc_advance, 0);
      chk("halt_cnt", retired_count, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle instruction sequencer for the accumulator datapath. It fetches one instruction at a time over a request/acknowledge port and decodes it. It then drives the register file control strobes (ACC write, GET, PUT, read-bus enable, status write), the ALU op select, the ACC-bus source select, and the data-memory handshake. It sits between instruction memory and the register file/ALU/data-memory datapath, and it is the only block that drives register file control inputs.

## Interface
- DATA_W, 8, datapath and immediate width
- INSTR_W, 16, instruction width; fields fixed as opcode=ir[15:12], imm=ir[11:4], reg=ir[3:0]
- REG_ADDR_WIDTH, 4, register address width
- COUNT_W, 16, retired-instruction counter width

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; one clock, synchronous, active-low
- run  in  1  level; permits starting a new fetch
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch acknowledge; instruction valid this cycle
- imem_rdata  in  INSTR_W  fetched instruction
- dmem_req  out  1  data memory request (address is register file dmar)
- dmem_we  out  1  1=store ACC, 0=load
- dmem_ack  in  1  data access complete; load data valid this cycle
- reg_addr  out  REG_ADDR_WIDTH  register file address
- acc_write_enable  out  1  to register file
- read_get_to_acc  out  1  to register file (GET)
- write_put_acc  out  1  to register file (PUT)
- read_data_output_enable  out  1  drives ALU operand-b bus
- status_write_enable  out  1  to register file
- acc_src  out  2  external ACC-bus driver: NONE/ALU/IMM/DMEM
- imm  out  DATA_W  immediate for IMM source
- alu_op  out  2  ADD/SUB/AND/OR
- pc_advance  out  1  one-cycle pulse when an instruction retires
- retired_count  out  COUNT_W  retired instructions, wraps
- halted  out  1  HALT executed
- illegal_op  out  1  one-cycle pulse on an undefined opcode

## Operation
- **Opcodes:** 0 NOP, 1 GET, 2 PUT, 3 LOADI, 4 LOAD, 5 STORE, 8–11 ALU, with alu_op=opcode[1:0]. 15 HALT. 6, 7 and 12–14 are illegal.
- **IDLE:** waits for run=1, then goes to FETCH.
- **FETCH:** imem_req=1 until imem_ack. On ack, load ir and go to DECODE.
- **DECODE:** one cycle. From here until the instruction leaves EXEC/MEM:
  - reg_addr=ir[3:0]
  - imm=ir[11:4]
  - alu_op=ir[13:12]
- **EXEC (single cycle):**
  - GET: read_get_to_acc=1, acc_write_enable=1, acc_src=NONE.
  - PUT: write_put_acc=1. Addresses the register file ignores still retire normally.
  - ALU: read_data_output_enable=1, acc_src=ALU, acc_write_enable=1, status_write_enable=1.
  - LOADI: acc_src=IMM, acc_write_enable=1.
  - NOP and illegal: no strobes. Illegal also pulses illegal_op.
  - LOAD/STORE: no strobes; go to MEM.
  - HALT: go to HALTED, with no retire.
- **MEM:**
  - dmem_req=1 held until dmem_ack. dmem_we=1 for STORE.
  - LOAD: in the ack cycle, acc_src=DMEM and acc_write_enable=1.
- **Retire:** occurs on the final EXEC/MEM cycle. pc_advance=1 and retired_count increments (wrapping at 2^COUNT_W).
  - Next state is FETCH if run=1, else IDLE.
  - Deasserting run never aborts an instruction already fetched.
- **HALTED:** halted=1. The block stays here until reset, and run is ignored.
- **Invariants:**
  - read_get_to_acc=1 implies acc_src=NONE.
  - write_put_acc and acc_write_enable are never asserted together.
  - All strobes are 0 outside EXEC/MEM.
  - dmem_req and imem_req are never asserted together.

## Timing
- **Reset:** synchronous. At the reset_n=0 clock edge:
  - State goes to IDLE; ir and retired_count go to 0.
  - All outputs go to 0, with acc_src=NONE and halted=0.
  - Applied mid-fetch or mid-memory access, reset drops the request the next cycle. A late ack is ignored.
- **Outputs:** all outputs are registered-state decodes (Moore); no input-to-output combinational path.
  - Exception: the LOAD-ack strobes in MEM depend combinationally on dmem_ack.
- **Latency with zero-wait memory (ack in the request cycle):**
  - Non-memory instruction: 3 cycles (FETCH, DECODE, EXEC).
  - LOAD/STORE: 4 cycles (adds MEM).
  - Each memory wait cycle adds 1.
- **Handshake:** a request holds until its ack, and the ack cycle completes the transfer. Ack while req=0 is ignored.
- **Throughput:** back-to-back with run held high, the next imem_req rises the cycle after pc_advance.

## Structure
- control_sequencer_pkg holds:
  - opcode_e (4-bit)
  - state_e: IDLE, FETCH, DECODE, EXEC, MEM, HALTED
  - acc_src_e: NONE=0, ALU=1, IMM=2, DMEM=3
  - alu_op_e
  - instruction field position constants
- REG_* address constants come from register_file_pkg and are not duplicated.
- Single module, no sub-modules. The decoder is one always_comb and the FSM is one always_ff.

## Test plan
- **LOADI, zero-wait:** reset, run=1, imem_rdata=0x3A50 (LOADI 0xA5) → on cycle 3, acc_src=IMM, imm=0xA5, acc_write_enable=1; then pc_advance=1 and retired_count=1.
- **PUT then GET:** 0x2003 (PUT R3) then 0x1003 (GET R3) → write_put_acc with reg_addr=3, then read_get_to_acc with acc_src=NONE; never both in one cycle.
- **ALU:** 0x9005 (SUB R5) → one cycle with read_data_output_enable, acc_write_enable and status_write_enable all 1, plus alu_op=1, acc_src=ALU.
- **LOAD with wait:** 0x4000 with dmem_ack delayed 3 cycles → dmem_req held 4 cycles with dmem_we=0; acc_write_enable and acc_src=DMEM only in the ack cycle; total 7 cycles.
- **Run and halt:** run dropped during a STORE → the store completes, then IDLE with no imem_req. Raise run and fetch 0xF000 → halted=1, no pc_advance, stays halted with run=1.
- **Illegal op and reset:** opcode 0x7 → illegal_op pulse, retires as NOP. Reset_n=0 during MEM → dmem_req=0 next cycle, state IDLE, retired_count=0.
